// File: rtl/up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
// Shared definitions for the up/down counter slice.
//   HEX_SEG    : 16-entry hex-to-7-segment table, active-low, bit 0 = segment a
//                (bit order {g,f,e,d,c,b,a}).
//   digits_for : number of hex digits needed to show a WIDTH-bit value,
//                i.e. ceil(width/4).
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic int unsigned digits_for(input int unsigned width);
        return (width + 32'd3) / 32'd4;
    endfunction

endpackage

// File: rtl/hexdisplay.sv
// -----------------------------------------------------------------------------
// hexdisplay
// Purely combinational decoder from one hex nibble to an active-low
// 7-segment glyph.
// Ports:
//   nibble : in  [3:0]  value to display
//   seg    : out [6:0]  active-low segments, bit 0 = a ... bit 6 = g
// -----------------------------------------------------------------------------
module hexdisplay
    import up_down_counter_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/up_down_counter.sv
// -----------------------------------------------------------------------------
// up_down_counter
// Loadable up/down counter with terminal count MAX, selectable wrap or
// saturate behaviour at both boundaries, a one-cycle boundary pulse, a
// sticky boundary flag and a multi-digit 7-segment rendering of the count.
//
// Parameters:
//   WIDTH  : counter width in bits (4..32)
//   MAX    : terminal count (1..2**WIDTH-1)
//   WRAP   : 1 = wrap at the boundary, 0 = saturate
//   DIGITS : number of hex digits driven on hex
// Ports:
//   clk      : in   rising-edge clock
//   clear    : in   asynchronous active-high reset
//   en       : in   count enable
//   up       : in   direction, 1 = increment, 0 = decrement
//   load     : in   synchronous load strobe (has priority over en)
//   load_val : in   [WIDTH-1:0]     value to load, clamped to MAX
//   q        : out  [WIDTH-1:0]     registered count
//   tc       : out  registered one-cycle boundary pulse
//   ovf      : out  registered sticky boundary flag (cleared by load/clear)
//   hex      : out  [7*DIGITS-1:0]  active-low segments, digit i on [7i+6:7i]
// -----------------------------------------------------------------------------
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}},
    parameter bit               WRAP   = 1'b1,
    parameter int unsigned      DIGITS = digits_for(WIDTH)
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      q,
    output logic                  tc,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   hex
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam int unsigned      PADW = 4 * DIGITS;

    logic [WIDTH-1:0] q_d;
    logic             tc_d;
    logic             ovf_d;

    // Next-state selection: load beats en; tc defaults low so it is a pulse.
    always_comb begin
        q_d   = q;
        tc_d  = 1'b0;
        ovf_d = ovf;
        if (load) begin
            q_d   = (load_val > MAX) ? MAX : load_val;
            ovf_d = 1'b0;
        end else if (en) begin
            if (up) begin
                if (q == MAX) begin
                    q_d   = WRAP ? '0 : MAX;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q + ONE;
                end
            end else begin
                if (q == '0) begin
                    q_d   = WRAP ? MAX : '0;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            q   <= q_d;
            tc  <= tc_d;
            ovf <= ovf_d;
        end
    end

    // Zero-pad q so digits above WIDTH decode a 0 nibble.
    logic [PADW-1:0] q_pad;

    if (PADW > WIDTH) begin : g_pad
        assign q_pad = {{(PADW - WIDTH){1'b0}}, q};
    end else begin : g_trunc
        assign q_pad = q[PADW-1:0];
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        hexdisplay u_hexdisplay (
            .nibble (q_pad[4*i +: 4]),
            .seg    (hex[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_up_down_counter.sv
// Four counter configurations run from one shared stimulus stream and are
// compared edge by edge against a plain-arithmetic reference model.
module tb_up_down_counter;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;

    always #5 clk = ~clk;

    // 0: WIDTH=16 default, 1: WIDTH=4 MAX=9 wrap, 2: WIDTH=4 MAX=9 saturate,
    // 3: WIDTH=8 MAX=200 wrap with 3 digits (top digit is padding)
    logic [15:0] q0;  logic tc0, ovf0;  logic [27:0] hex0;
    logic [3:0]  q1;  logic tc1, ovf1;  logic [6:0]  hex1;
    logic [3:0]  q2;  logic tc2, ovf2;  logic [6:0]  hex2;
    logic [7:0]  q3;  logic tc3, ovf3;  logic [20:0] hex3;

    up_down_counter u_d16 (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
        .q(q0), .tc(tc0), .ovf(ovf0), .hex(hex0)
    );
    up_down_counter #(.WIDTH(4), .MAX(4'd9), .WRAP(1'b1)) u_d4w (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .q(q1), .tc(tc1), .ovf(ovf1), .hex(hex1)
    );
    up_down_counter #(.WIDTH(4), .MAX(4'd9), .WRAP(1'b0)) u_d4s (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .q(q2), .tc(tc2), .ovf(ovf2), .hex(hex2)
    );
    up_down_counter #(.WIDTH(8), .MAX(8'd200), .WRAP(1'b1), .DIGITS(3)) u_d8 (
        .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
        .q(q3), .tc(tc3), .ovf(ovf3), .hex(hex3)
    );

    logic [31:0] obs_q [4];
    logic        obs_tc [4];
    logic        obs_ovf [4];
    logic [31:0] obs_hex [4];
    assign obs_q[0] = {16'd0, q0};  assign obs_tc[0] = tc0;  assign obs_ovf[0] = ovf0;
    assign obs_q[1] = {28'd0, q1};  assign obs_tc[1] = tc1;  assign obs_ovf[1] = ovf1;
    assign obs_q[2] = {28'd0, q2};  assign obs_tc[2] = tc2;  assign obs_ovf[2] = ovf2;
    assign obs_q[3] = {24'd0, q3};  assign obs_tc[3] = tc3;  assign obs_ovf[3] = ovf3;
    assign obs_hex[0] = {4'd0, hex0};
    assign obs_hex[1] = {25'd0, hex1};
    assign obs_hex[2] = {25'd0, hex2};
    assign obs_hex[3] = {11'd0, hex3};

    // Reference model configuration and state
    int unsigned cfg_max  [4] = '{65535, 9, 9, 200};
    int unsigned cfg_mask [4] = '{32'hFFFF, 32'hF, 32'hF, 32'hFF};
    bit          cfg_wrap [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int unsigned cfg_dig  [4] = '{4, 1, 1, 3};

    int unsigned m_q [4];
    bit          m_tc [4];
    bit          m_ovf [4];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] glyph(input int unsigned n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [31:0] exp_hex(input int unsigned qv, input int unsigned digits);
        logic [31:0] r = '0;
        for (int d = 0; d < int'(digits); d++) r[7*d +: 7] = glyph((qv >> (4*d)) & 32'hF);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_q[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
        end
    endfunction

    function automatic void model_edge(input bit ld, input bit e, input bit u, input int unsigned lv);
        for (int i = 0; i < 4; i++) begin
            int unsigned v = lv & cfg_mask[i];
            m_tc[i] = 1'b0;
            if (ld) begin
                m_q[i]   = (v > cfg_max[i]) ? cfg_max[i] : v;
                m_ovf[i] = 1'b0;
            end else if (e && u) begin
                if (m_q[i] == cfg_max[i]) begin
                    m_q[i] = cfg_wrap[i] ? 0 : cfg_max[i];
                    m_tc[i] = 1'b1; m_ovf[i] = 1'b1;
                end else m_q[i] = m_q[i] + 1;
            end else if (e) begin
                if (m_q[i] == 0) begin
                    m_q[i] = cfg_wrap[i] ? cfg_max[i] : 0;
                    m_tc[i] = 1'b1; m_ovf[i] = 1'b1;
                end else m_q[i] = m_q[i] - 1;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.q[%0d]", tag, i), obs_q[i], m_q[i]);
            check($sformatf("%s.tc[%0d]", tag, i), {31'd0, obs_tc[i]}, {31'd0, m_tc[i]});
            check($sformatf("%s.ovf[%0d]", tag, i), {31'd0, obs_ovf[i]}, {31'd0, m_ovf[i]});
            check($sformatf("%s.hex[%0d]", tag, i), obs_hex[i], exp_hex(m_q[i], cfg_dig[i]));
        end
    endtask

    // One rising edge with the inputs currently driven, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (clear) model_reset();
        else model_edge(load, en, up, {16'd0, load_val});
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit ld, input bit e, input bit u, input logic [15:0] lv);
        load = ld; en = e; up = u; load_val = lv;
    endtask

    // Asynchronous clear mid-cycle, held across one edge with active inputs.
    task automatic clear_pulse(input string tag);
        @(negedge clk); #2;
        clear = 1'b1;
        #1;
        model_reset();
        check_all({tag, ".async"});
        drive(1'b1, 1'b1, 1'b1, 16'h0005);
        step({tag, ".held"});
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        logic [15:0] pool [7];
        pool = '{16'd0, 16'd9, 16'd200, 16'd250, 16'hFFFF, 16'h1234, 16'd199};
        model_reset();

        #3;
        check_all("reset");
        clear = 1'b0;

        // Five up edges from zero
        drive(1'b0, 1'b1, 1'b1, 16'd0);
        for (int k = 0; k < 5; k++) step("up5");
        check("up5.q", {16'd0, q0}, 32'd5);
        check("up5.hex0", {25'd0, hex0[6:0]}, 32'b0010010);
        check("up5.tc", {31'd0, tc0}, 32'd0);

        // Load 9 then one up edge: wrap for MAX=9 configs, tc one cycle, ovf sticky
        drive(1'b1, 1'b0, 1'b1, 16'd9);
        step("ld9");
        drive(1'b0, 1'b1, 1'b1, 16'd0);
        step("wrap9");
        check("wrap9.q", {28'd0, q1}, 32'd0);
        check("wrap9.tc", {31'd0, tc1}, 32'd1);
        check("sat9.q", {28'd0, q2}, 32'd9);
        drive(1'b0, 1'b0, 1'b1, 16'd0);
        step("hold");
        check("hold.tc", {31'd0, tc1}, 32'd0);
        check("hold.ovf", {31'd0, ovf1}, 32'd1);

        // Saturating down at zero: tc on every enabled edge
        drive(1'b1, 1'b0, 1'b0, 16'd0);
        step("ld0");
        drive(1'b0, 1'b1, 1'b0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            step("satdn");
            check("satdn.q", {28'd0, q2}, 32'd0);
            check("satdn.tc", {31'd0, tc2}, 32'd1);
        end
        check("satdn.ovf", {31'd0, ovf2}, 32'd1);

        // Load clamp to MAX=200, then wrap up
        drive(1'b1, 1'b0, 1'b1, 16'd250);
        step("ld250");
        check("clamp.q", {24'd0, q3}, 32'd200);
        drive(1'b0, 1'b1, 1'b1, 16'd0);
        step("wrap200");
        check("wrap200.q", {24'd0, q3}, 32'd0);

        // Load wins over en and clears ovf
        drive(1'b1, 1'b1, 1'b1, 16'h0003);
        step("ldEn");
        check("ldEn.q", {16'd0, q0}, 32'd3);
        check("ldEn.ovf", {31'd0, ovf3}, 32'd0);

        // Async clear while q=0x1234
        drive(1'b1, 1'b0, 1'b0, 16'h1234);
        step("ld1234");
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        clear_pulse("clr1234");
        check("clr1234.hex", {4'd0, hex0}, {4'd0, {4{7'b1000000}}});

        // Randomized traffic
        for (int it = 0; it < 500; it++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 6)] : 16'($urandom));
            step("rnd");
            if ($urandom_range(0, 59) == 0) clear_pulse("rndclr");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
